// File: rtl/or_nway_reduce_if.sv
// ---------------------------------------------------------------------------
// or_nway_reduce_if
// Bundles the word-input and result-output handshakes of or_nway_reduce.
//   in_valid/in_ready/in_data/in_last/mode : word stream from the producer
//   out_valid/out_ready/out/out_count/out_trunc : per-frame result stream
// Modports:
//   slave  : the reducer itself (consumes words, produces results)
//   master : the surrounding logic (produces words, consumes results)
// ---------------------------------------------------------------------------
interface or_nway_reduce_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16
);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic             out;
    logic [CNT_W-1:0] out_count;
    logic             out_trunc;

    modport master (
        output in_valid, in_data, in_last, mode, out_ready,
        input  in_ready, out_valid, out, out_count, out_trunc
    );

    modport slave (
        input  in_valid, in_data, in_last, mode, out_ready,
        output in_ready, out_valid, out, out_count, out_trunc
    );
endinterface

// File: rtl/or_nway_reduce.sv
// ---------------------------------------------------------------------------
// or_nway_reduce
// Reduces each WIDTH-bit input word to one bit and combines those bits over a
// frame of up to MAX_WORDS words with a per-frame mode (OR, AND, XOR, NOR).
// One registered result per frame is presented on the output handshake.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : or_nway_reduce_if.slave (word input stream + result output stream)
// ---------------------------------------------------------------------------
module or_nway_reduce #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16
) (
    input logic           clk,
    input logic           rst_n,
    or_nway_reduce_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] MODE_OR  = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_NOR = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             res_q, res_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic             res_trunc_q, res_trunc_d;

    logic [1:0]       eff_mode;
    logic             word_r;
    logic             acc_next;
    logic [CNT_W-1:0] count_next;
    logic             frame_full;
    logic             in_fire;
    logic             out_fire;

    // in_ready is gated by rst_n so nothing is accepted while reset is held.
    assign bus.in_ready  = rst_n && (state_q != DONE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = res_q;
    assign bus.out_count = res_count_q;
    assign bus.out_trunc = res_trunc_q;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    // Word reduction and accumulation. The first word of a frame takes the
    // live mode input; later words use the mode latched with that first word.
    always_comb begin
        eff_mode = (state_q == IDLE) ? bus.mode : mode_q;

        case (eff_mode)
            MODE_AND: word_r = &bus.in_data;
            MODE_XOR: word_r = ^bus.in_data;
            default:  word_r = |bus.in_data;
        endcase

        if (state_q == IDLE) begin
            acc_next   = word_r;
            count_next = CNT_W'(1);
        end else begin
            count_next = count_q + CNT_W'(1);
            case (mode_q)
                MODE_AND: acc_next = acc_q & word_r;
                MODE_XOR: acc_next = acc_q ^ word_r;
                default:  acc_next = acc_q | word_r;
            endcase
        end

        frame_full = (count_next == CNT_W'(MAX_WORDS));
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        count_d     = count_q;
        res_d       = res_q;
        res_count_d = res_count_q;
        res_trunc_d = res_trunc_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (in_fire) begin
                    mode_d  = eff_mode;
                    acc_d   = acc_next;
                    count_d = count_next;
                    if (bus.in_last || frame_full) begin
                        state_d     = DONE;
                        res_d       = (eff_mode == MODE_NOR) ? ~acc_next : acc_next;
                        res_count_d = count_next;
                        // Truncated only when the size limit, not in_last, closed it.
                        res_trunc_d = !bus.in_last;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_OR;
            acc_q       <= 1'b0;
            count_q     <= '0;
            res_q       <= 1'b0;
            res_count_q <= '0;
            res_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            res_q       <= res_d;
            res_count_q <= res_count_d;
            res_trunc_q <= res_trunc_d;
        end
    end
endmodule

// File: tb/tb_or_nway_reduce.sv
// ---------------------------------------------------------------------------
// tb_or_nway_reduce
// Self-checking bench for or_nway_reduce with WIDTH=8, MAX_WORDS=4.
// The reference model splits the word stream into frames and evaluates each
// frame result from whole-frame properties (any word nonzero, all words
// all-ones, number of odd-parity words).
// ---------------------------------------------------------------------------
module tb_or_nway_reduce;
    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 4;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    or_nway_reduce_if #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) bus ();

    or_nway_reduce #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic             res;
        logic [CNT_W-1:0] cnt;
        logic             trunc;
    } res_t;

    logic [WIDTH-1:0] st_data[$];
    logic             st_last[$];
    logic [1:0]       st_mode[$];
    res_t             exp_q[$];
    res_t             got_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic clear_stim();
        st_data.delete();
        st_last.delete();
        st_mode.delete();
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d, input logic l, input logic [1:0] m);
        st_data.push_back(d);
        st_last.push_back(l);
        st_mode.push_back(m);
    endtask

    // Frame-level reference: a frame ends on in_last or on its MAX_WORDS-th word;
    // its mode is whatever accompanied its first word.
    function automatic void model_frames();
        int         cnt = 0;
        bit         any_nz = 1'b0;
        bit         all_ff = 1'b1;
        int         odd = 0;
        logic [1:0] fm = 2'b00;
        res_t       r;
        exp_q.delete();
        for (int i = 0; i < st_data.size(); i++) begin
            if (cnt == 0) begin
                fm = st_mode[i]; any_nz = 1'b0; all_ff = 1'b1; odd = 0;
            end
            cnt++;
            if (st_data[i] != 0) any_nz = 1'b1;
            if (st_data[i] != 8'hFF) all_ff = 1'b0;
            if ($countones(st_data[i]) % 2 == 1) odd++;
            if (st_last[i] || cnt == MAX_WORDS) begin
                case (fm)
                    2'b00:   r.res = any_nz;
                    2'b01:   r.res = all_ff;
                    2'b10:   r.res = (odd % 2 == 1);
                    default: r.res = !any_nz;
                endcase
                r.cnt   = CNT_W'(cnt);
                r.trunc = !st_last[i];
                exp_q.push_back(r);
                cnt = 0;
            end
        end
    endfunction

    // Drives the loaded stimulus and collects every output beat. Called and
    // returns at a falling edge. Optional input gaps and random out_ready.
    task automatic run_stream(input bit gaps, input bit rand_ready, output bit timed_out);
        int   idx = 0;
        int   cyc = 0;
        int   n = st_data.size();
        res_t g;
        got_q.delete();
        timed_out = 1'b0;
        while (idx < n || got_q.size() < exp_q.size()) begin
            if (cyc >= 2000) begin
                timed_out = 1'b1;
                break;
            end
            bus.in_valid  = (idx < n) && (!gaps || $urandom_range(0, 3) != 0);
            bus.in_data   = bus.in_valid ? st_data[idx] : WIDTH'($urandom);
            bus.in_last   = bus.in_valid ? st_last[idx] : 1'($urandom);
            bus.mode      = bus.in_valid ? st_mode[idx] : 2'($urandom);
            bus.out_ready = !rand_ready || ($urandom_range(0, 2) != 0);
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid && bus.out_ready) begin
                g.res = bus.out; g.cnt = bus.out_count; g.trunc = bus.out_trunc;
                got_q.push_back(g);
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.in_last = 1'b1;
        bus.mode = 2'b00; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out !== 1'b0) $display("FAIL reset_out got=%b exp=0", bus.out); else n_pass++;
        n_checks++; if (bus.out_count !== '0) $display("FAIL reset_out_count got=%0d exp=0", bus.out_count); else n_pass++;
        n_checks++; if (bus.out_trunc !== 1'b0) $display("FAIL reset_out_trunc got=%b exp=0", bus.out_trunc); else n_pass++;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL post_reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_or_single();
        bit to;
        clear_stim();
        push_word(8'h00, 1'b1, 2'b00);
        push_word(8'hFF, 1'b1, 2'b00);
        push_word(8'hAA, 1'b1, 2'b00);
        push_word(8'h01, 1'b1, 2'b00);
        model_frames();
        run_stream(1'b0, 1'b0, to);
        n_checks++; if (to) $display("FAIL or_single_timeout got=%0d exp=%0d results", got_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL or_single_nres got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL or_single[%0d] got out=%b cnt=%0d trunc=%b exp out=%b cnt=%0d trunc=%b", i, got_q[i].res, got_q[i].cnt, got_q[i].trunc, exp_q[i].res, exp_q[i].cnt, exp_q[i].trunc);
            else n_pass++;
            $display("or_single frame %0d: out=%b count=%0d trunc=%b", i, got_q[i].res, got_q[i].cnt, got_q[i].trunc);
        end
    endtask

    task automatic test_and();
        bit to;
        clear_stim();
        push_word(8'hFF, 1'b0, 2'b01);
        push_word(8'hFF, 1'b0, 2'b01);
        push_word(8'h7F, 1'b1, 2'b01);
        push_word(8'hFF, 1'b0, 2'b01);
        push_word(8'hFF, 1'b0, 2'b01);
        push_word(8'hFF, 1'b1, 2'b01);
        model_frames();
        run_stream(1'b0, 1'b0, to);
        n_checks++; if (to) $display("FAIL and_timeout got=%0d exp=%0d results", got_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL and_nres got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL and[%0d] got out=%b cnt=%0d trunc=%b exp out=%b cnt=%0d trunc=%b", i, got_q[i].res, got_q[i].cnt, got_q[i].trunc, exp_q[i].res, exp_q[i].cnt, exp_q[i].trunc);
            else n_pass++;
            $display("and frame %0d: out=%b count=%0d trunc=%b", i, got_q[i].res, got_q[i].cnt, got_q[i].trunc);
        end
    endtask

    task automatic test_xor_nor();
        bit to;
        clear_stim();
        push_word(8'h01, 1'b0, 2'b10);
        push_word(8'h03, 1'b1, 2'b10);
        push_word(8'h00, 1'b0, 2'b11);
        push_word(8'h00, 1'b1, 2'b11);
        push_word(8'h00, 1'b0, 2'b11);
        push_word(8'h80, 1'b1, 2'b00);  // mode on a non-first word must be ignored
        model_frames();
        run_stream(1'b0, 1'b0, to);
        n_checks++; if (to) $display("FAIL xor_nor_timeout got=%0d exp=%0d results", got_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL xor_nor_nres got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL xor_nor[%0d] got out=%b cnt=%0d trunc=%b exp out=%b cnt=%0d trunc=%b", i, got_q[i].res, got_q[i].cnt, got_q[i].trunc, exp_q[i].res, exp_q[i].cnt, exp_q[i].trunc);
            else n_pass++;
            $display("xor_nor frame %0d: out=%b count=%0d trunc=%b", i, got_q[i].res, got_q[i].cnt, got_q[i].trunc);
        end
    endtask

    task automatic test_trunc();
        bit to;
        clear_stim();
        push_word(8'h00, 1'b0, 2'b00);
        push_word(8'h00, 1'b0, 2'b00);
        push_word(8'h00, 1'b0, 2'b00);
        push_word(8'h00, 1'b0, 2'b00);
        push_word(8'h10, 1'b1, 2'b00);
        model_frames();
        run_stream(1'b0, 1'b0, to);
        n_checks++; if (to) $display("FAIL trunc_timeout got=%0d exp=%0d results", got_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL trunc_nres got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL trunc[%0d] got out=%b cnt=%0d trunc=%b exp out=%b cnt=%0d trunc=%b", i, got_q[i].res, got_q[i].cnt, got_q[i].trunc, exp_q[i].res, exp_q[i].cnt, exp_q[i].trunc);
            else n_pass++;
            $display("trunc frame %0d: out=%b count=%0d trunc=%b", i, got_q[i].res, got_q[i].cnt, got_q[i].trunc);
        end
    endtask

    task automatic test_backpressure();
        bus.mode = 2'b00; bus.in_data = 8'h55; bus.in_last = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_in_ready_before got=%b exp=1", bus.in_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        bus.in_data = 8'h00;  // would change the result if wrongly accepted
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_latency got=%b exp=1", bus.out_valid); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid c=%0d got=%b exp=1", c, bus.out_valid); else n_pass++;
            n_checks++; if (bus.out !== 1'b1) $display("FAIL bp_out c=%0d got=%b exp=1", c, bus.out); else n_pass++;
            n_checks++; if (bus.out_count !== CNT_W'(1)) $display("FAIL bp_out_count c=%0d got=%0d exp=1", c, bus.out_count); else n_pass++;
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, bus.in_ready); else n_pass++;
            $display("backpressure cycle %0d: out_valid=%b out=%b count=%0d in_ready=%b", c, bus.out_valid, bus.out, bus.out_count, bus.in_ready);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_in_ready_after got=%b exp=1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_out_valid_after got=%b exp=0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        bit to;
        bus.mode = 2'b01; bus.in_data = 8'hFF; bus.in_last = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL midrst_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out !== 1'b0) $display("FAIL midrst_out got=%b exp=0", bus.out); else n_pass++;
        n_checks++; if (bus.out_count !== '0) $display("FAIL midrst_out_count got=%0d exp=0", bus.out_count); else n_pass++;
        n_checks++; if (bus.out_trunc !== 1'b0) $display("FAIL midrst_out_trunc got=%b exp=0", bus.out_trunc); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_stim();
        push_word(8'hFF, 1'b1, 2'b01);
        model_frames();
        run_stream(1'b0, 1'b0, to);
        n_checks++; if (to) $display("FAIL midrst_timeout got=%0d exp=%0d results", got_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL midrst_nres got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL midrst[%0d] got out=%b cnt=%0d trunc=%b exp out=%b cnt=%0d trunc=%b", i, got_q[i].res, got_q[i].cnt, got_q[i].trunc, exp_q[i].res, exp_q[i].cnt, exp_q[i].trunc);
            else n_pass++;
            $display("midrst frame %0d: out=%b count=%0d trunc=%b", i, got_q[i].res, got_q[i].cnt, got_q[i].trunc);
        end
    endtask

    task automatic test_random();
        bit               to;
        logic [WIDTH-1:0] d;
        clear_stim();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0:       d = 8'h00;
                1:       d = 8'hFF;
                default: d = WIDTH'($urandom);
            endcase
            push_word(d, ($urandom_range(0, 2) == 0), 2'($urandom));
        end
        model_frames();
        run_stream(1'b1, 1'b1, to);
        n_checks++; if (to) $display("FAIL random_timeout got=%0d exp=%0d results", got_q.size(), exp_q.size()); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL random_nres got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL random[%0d] got out=%b cnt=%0d trunc=%b exp out=%b cnt=%0d trunc=%b", i, got_q[i].res, got_q[i].cnt, got_q[i].trunc, exp_q[i].res, exp_q[i].cnt, exp_q[i].trunc);
            else n_pass++;
            $display("random frame %0d: out=%b count=%0d trunc=%b", i, got_q[i].res, got_q[i].cnt, got_q[i].trunc);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.mode      = 2'b00;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_or_single();
        test_and();
        test_xor_nor();
        test_trunc();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
